// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
//   Shared definitions for the execute-stage multiply/divide unit:
//   operation encodings, FSM state encoding, and the magnitude/negate helpers
//   used for the signed forms of MULT and DIV.
//   The helpers are sized by MD_WIDTH. muldiv_unit must be built with a WIDTH
//   equal to MD_WIDTH.
// -----------------------------------------------------------------------------
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_e;

  // Signed ops take operand magnitudes; result signs are fixed up at the end.
  function automatic logic opIsSigned(input logic [1:0] o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

  function automatic logic opIsDiv(input logic [1:0] o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  // One extra bit so that the magnitude of -2^(W-1) is representable.
  function automatic logic [MD_WIDTH:0] absWide(input logic [MD_WIDTH-1:0] value,
                                                input logic isSigned);
    logic [MD_WIDTH:0] result;
    if (isSigned && value[MD_WIDTH-1]) begin
      result = {1'b0, ~value} + {{MD_WIDTH{1'b0}}, 1'b1};
    end else begin
      result = {1'b0, value};
    end
    return result;
  endfunction

  function automatic logic [MD_WIDTH-1:0] negW(input logic [MD_WIDTH-1:0] value);
    return ~value + {{(MD_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*MD_WIDTH-1:0] neg2W(input logic [2*MD_WIDTH-1:0] value);
    return ~value + {{(2*MD_WIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO pair.
//   One iteration per clock (WIDTH iterations), followed by one sign-fix cycle
//   that writes HI/LO and pulses done. HI/LO never show partial results.
// Ports
//   clock    : clock, all state on posedge
//   reset_   : asynchronous active-low reset
//   start    : issue request, sampled only in IDLE
//   op       : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_data  : multiplicand / dividend
//   rt_data  : multiplier / divisor
//   hi_we    : MTHI, load wdata into HI (IDLE only, start has priority)
//   lo_we    : MTLO, load wdata into LO (IDLE only, start has priority)
//   wdata    : MTHI/MTLO data
//   busy     : operation in flight
//   done     : one-cycle pulse, HI/LO hold the new result
//   hi, lo   : HI / LO registers
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  md_state_e          state_r, nextState_s;
  logic [CW-1:0]      counter_r;
  // Multiply: {carry/upper(W+1), multiplier/lower(W)}.
  // Divide:   {remainder(W+1), dividend shifting into quotient(W)}.
  logic [2*WIDTH:0]   acc_r;
  logic [WIDTH-1:0]   operandB_r;
  logic               isDiv_r;
  logic               negResult_r;
  logic               negRemainder_r;
  logic               divZero_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               opSigned_s;
  logic               opDiv_s;
  logic [WIDTH:0]     rsMag_s;
  logic [WIDTH:0]     rtMag_s;
  logic [WIDTH:0]     addA_s;
  logic [WIDTH:0]     addB_s;
  logic [WIDTH+1:0]   addSum_s;
  logic [2*WIDTH:0]   accNext_s;
  logic [2*WIDTH-1:0] product_s;
  logic [WIDTH-1:0]   fixHi_s;
  logic [WIDTH-1:0]   fixLo_s;

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

  // FSM state register.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          nextState_s = RUN;
        end else begin
          nextState_s = IDLE;
        end
      end
      RUN: begin
        if (counter_r == LAST_ITER) begin
          nextState_s = FIX;
        end else begin
          nextState_s = RUN;
        end
      end
      FIX:     nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // Operand decode and magnitudes at issue.
  always_comb begin
    opSigned_s = opIsSigned(op);
    opDiv_s    = opIsDiv(op);
    rsMag_s    = absWide(rs_data, opSigned_s);
    rtMag_s    = absWide(rt_data, opSigned_s);
  end

  // Shared adder operand select: multiply adds the multiplicand into the upper
  // half; divide compares the left-shifted remainder against the divisor.
  always_comb begin
    addA_s = '0;
    addB_s = '0;
    if (isDiv_r) begin
      addA_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
      addB_s = {1'b0, operandB_r};
    end else begin
      addA_s = acc_r[2*WIDTH:WIDTH];
      if (acc_r[0]) begin
        addB_s = {1'b0, operandB_r};
      end else begin
        addB_s = '0;
      end
    end
  end

  // Single adder/subtractor; subtraction as A + ~B + 1, MSB is the borrow.
  assign addSum_s = {1'b0, addA_s}
                  + ({1'b0, addB_s} ^ {(WIDTH+2){isDiv_r}})
                  + {{(WIDTH+1){1'b0}}, isDiv_r};

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    accNext_s = acc_r;
    if (isDiv_r) begin
      if (addSum_s[WIDTH+1]) begin
        accNext_s = {addA_s, acc_r[WIDTH-2:0], 1'b0};
      end else begin
        accNext_s = {1'b0, addSum_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end
    end else begin
      accNext_s = {1'b0, addSum_s[WIDTH:0], acc_r[WIDTH-1:1]};
    end
  end

  // Final sign correction of the unsigned result.
  always_comb begin
    product_s = acc_r[2*WIDTH-1:0];
    fixHi_s   = hi_r;
    fixLo_s   = lo_r;
    if (isDiv_r) begin
      if (divZero_r) begin
        fixLo_s = {WIDTH{1'b1}};
      end else if (negResult_r) begin
        fixLo_s = negW(acc_r[WIDTH-1:0]);
      end else begin
        fixLo_s = acc_r[WIDTH-1:0];
      end
      // With a zero divisor the remainder is |rs| with rs's sign, i.e. rs itself.
      if (negRemainder_r) begin
        fixHi_s = negW(acc_r[2*WIDTH-1:WIDTH]);
      end else begin
        fixHi_s = acc_r[2*WIDTH-1:WIDTH];
      end
    end else begin
      if (negResult_r) begin
        {fixHi_s, fixLo_s} = neg2W(product_s);
      end else begin
        {fixHi_s, fixLo_s} = product_s;
      end
    end
  end

  // Control outputs and iteration counter.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      counter_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            busy_r    <= 1'b1;
            counter_r <= '0;
          end
        end
        RUN: counter_r <= counter_r + {{(CW-1){1'b0}}, 1'b1};
        FIX: begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
        default: busy_r <= 1'b0;
      endcase
    end
  end

  // Operand latch at issue and accumulator update while running.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      acc_r          <= '0;
      operandB_r     <= '0;
      isDiv_r        <= 1'b0;
      negResult_r    <= 1'b0;
      negRemainder_r <= 1'b0;
      divZero_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            isDiv_r        <= opDiv_s;
            negResult_r    <= opSigned_s & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            negRemainder_r <= opSigned_s & rs_data[WIDTH-1];
            divZero_r      <= opDiv_s & (rt_data == {WIDTH{1'b0}});
            if (opDiv_s) begin
              acc_r      <= {{(WIDTH+1){1'b0}}, rsMag_s[WIDTH-1:0]};
              operandB_r <= rtMag_s[WIDTH-1:0];
            end else begin
              acc_r      <= {{(WIDTH+1){1'b0}}, rtMag_s[WIDTH-1:0]};
              operandB_r <= rsMag_s[WIDTH-1:0];
            end
          end
        end
        RUN:     acc_r <= accNext_s;
        FIX:     acc_r <= acc_r;
        default: acc_r <= acc_r;
      endcase
    end
  end

  // HI/LO: MTHI/MTLO in IDLE unless start is taken; result written in FIX.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      hi_r <= '0;
      lo_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!start) begin
            if (hi_we) begin
              hi_r <= wdata;
            end
            if (lo_we) begin
              lo_r <= wdata;
            end
          end
        end
        FIX: begin
          hi_r <= fixHi_s;
          lo_r <= fixLo_s;
        end
        RUN:     hi_r <= hi_r;
        default: hi_r <= hi_r;
      endcase
    end
  end

endmodule
